core_bus_arbiter: RTL and testbench

- Sits directly downstream of the core's ibus/dbus ports.
- Serialises instruction-fetch and data-memory requests onto the single cache/memory bus (cbus).
- Returns per-client addr_ok/data_ok handshakes, which the core uses to stall the PC and the memory stage.
- Single-beat transactions only; one outstanding transaction at a time; includes a watchdog for hung responses.

---
 rtl/core_bus_arbiter_pkg.sv | 84 ++++++++
 rtl/core_bus_arbiter_if.sv | 26 ++
 rtl/core_bus_arbiter_bus_watchdog.sv | 47 ++++
 rtl/core_bus_arbiter.sv | 104 ++++++++++
 tb/tb_core_bus_arbiter.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_bus_arbiter_pkg.sv
// Shared types for the core-to-cache bus arbiter.
// Holds the ibus/dbus/cbus request and response structs, the memory access
// size encoding, the arbiter state type with its state constants, and two
// helpers that map a client request onto a single-beat cbus request.
package core_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    msize_t      size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic [7:0]  len;
    logic        burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

  // State encoding kept as plain constants so existing code that compares
  // against the raw two-bit value keeps working.
  typedef logic [1:0] arb_state_t;
  localparam arb_state_t ST_IDLE   = 2'd0;
  localparam arb_state_t ST_BUSY_I = 2'd1;
  localparam arb_state_t ST_BUSY_D = 2'd2;

  // Fetches are always 4-byte reads. valid, len and burst stay 0.
  function automatic cbus_req_t ibus_to_cbus(input ibus_req_t req);
    cbus_req_t c;
    c      = '0;
    c.size = MSIZE4;
    c.addr = req.addr;
    return c;
  endfunction

  // Any enabled byte lane makes the access a write.
  function automatic cbus_req_t dbus_to_cbus(input dbus_req_t req);
    cbus_req_t c;
    c          = '0;
    c.is_write = |req.strobe;
    c.size     = req.size;
    c.addr     = req.addr;
    c.strobe   = req.strobe;
    c.data     = req.data;
    return c;
  endfunction

endpackage

// File: rtl/core_bus_arbiter_if.sv
// Bundle of the three buses around the arbiter.
//   ireq/iresp : instruction-fetch client
//   dreq/dresp : data-memory client
//   creq/cresp : shared cache/memory bus
// slave  : the arbiter's view (takes client requests and cbus responses).
// master : the surrounding system's view (core clients and cache).
interface core_bus_arbiter_if;
  import core_bus_arbiter_pkg::*;

  ibus_req_t  ireq;
  ibus_resp_t iresp;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  cbus_req_t  creq;
  cbus_resp_t cresp;

  modport slave (
    input  ireq, dreq, cresp,
    output iresp, dresp, creq
  );

  modport master (
    output ireq, dreq, cresp,
    input  iresp, dresp, creq
  );
endinterface

// File: rtl/core_bus_arbiter_bus_watchdog.sv
// Busy-cycle watchdog for the bus arbiter.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   i_busy     : a transaction is outstanding this cycle
//   i_done     : the outstanding transaction completes this cycle
//   o_err      : sticky error, set once a transaction has waited TIMEOUT cycles
// The counter saturates instead of wrapping; TIMEOUT=0 disables the error.
module bus_watchdog #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_busy,
  input  logic i_done,
  output logic o_err
);

  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam bit               ENABLE  = (TIMEOUT != 0);

  logic [CNT_W-1:0] r_count;
  logic             r_err;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register here samples the
    // pre-edge value of r_count, independent of statement order.
    if (reset) begin
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (!i_busy || i_done) begin
        r_count <= '0;
      end else if (r_count != CNT_MAX) begin
        r_count <= r_count + CNT_W'(1);
      end
      // Counter reads TIMEOUT-1 in the TIMEOUT-th busy cycle.
      if (ENABLE && i_busy && !i_done && (r_count == LIMIT)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_err = r_err;

endmodule

// File: rtl/core_bus_arbiter.sv
// Serialises ibus fetches and dbus accesses onto the single cbus.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   bus        : ireq/iresp, dreq/dresp, creq/cresp (slave modport)
//   err        : sticky watchdog error for a hung cbus response
// One single-beat transaction at a time. addr_ok pulses combinationally in
// the granting IDLE cycle; creq is driven from the latched request from the
// next cycle until completion (ready & last), when data_ok pulses to the
// owning client and the arbiter returns to IDLE.
module core_bus_arbiter
  import core_bus_arbiter_pkg::*;
#(
  parameter int DATA_PRIO = 1,
  parameter int TIMEOUT   = 1024,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  core_bus_arbiter_if.slave bus,
  output logic              err
);

  arb_state_t r_state;
  cbus_req_t  r_req;

  logic w_idle_ok;
  logic w_grant_i;
  logic w_grant_d;
  logic w_busy;
  logic w_done;
  logic w_done_i;
  logic w_done_d;

  // No handshake is issued in a reset cycle, so an abandoned transaction
  // never produces a late data_ok and nothing is granted while reset is held.
  assign w_idle_ok = (r_state == ST_IDLE) && !reset;
  assign w_grant_d = w_idle_ok && bus.dreq.valid && (!bus.ireq.valid || (DATA_PRIO != 0));
  assign w_grant_i = w_idle_ok && bus.ireq.valid && (!bus.dreq.valid || (DATA_PRIO == 0));

  assign w_busy   = (r_state != ST_IDLE);
  // ready without last is illegal for len=0 and is ignored.
  assign w_done   = w_busy && !reset && bus.cresp.ready && bus.cresp.last;
  assign w_done_i = w_done && (r_state == ST_BUSY_I);
  assign w_done_d = w_done && (r_state == ST_BUSY_D);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_req   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_d) begin
            r_state <= ST_BUSY_D;
            r_req   <= dbus_to_cbus(bus.dreq);
          end else if (w_grant_i) begin
            r_state <= ST_BUSY_I;
            r_req   <= ibus_to_cbus(bus.ireq);
          end
        end
        // Return to IDLE only; the next grant happens in that IDLE cycle.
        ST_BUSY_I, ST_BUSY_D: begin
          if (w_done) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    // NOTE: every output gets a full default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    bus.creq       = r_req;
    bus.creq.valid = w_busy;

    bus.iresp         = '0;
    bus.iresp.addr_ok = w_grant_i;
    bus.iresp.data_ok = w_done_i;
    if (w_done_i) begin
      bus.iresp.data = r_req.addr[2] ? bus.cresp.data[63:32] : bus.cresp.data[31:0];
    end

    bus.dresp         = '0;
    bus.dresp.addr_ok = w_grant_d;
    bus.dresp.data_ok = w_done_d;
    if (w_done_d) begin
      bus.dresp.data = bus.cresp.data;
    end
  end

  bus_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .i_busy (w_busy),
    .i_done (w_done),
    .o_err  (err)
  );

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Bench for core_bus_arbiter: two instances (A: data priority, B: fetch
// priority), both with an 8-cycle watchdog, driven by directed vectors.
// A transaction-level model is checked against both on every cycle, and
// hand-computed literals pin the key points of each scenario.
module tb_core_bus_arbiter;
  import core_bus_arbiter_pkg::*;

  localparam int TB_TIMEOUT = 8;

  logic clk;
  logic reset;

  ibus_req_t  ireq  [2];
  dbus_req_t  dreq  [2];
  cbus_resp_t cresp [2];

  ibus_resp_t iresp_o [2];
  dbus_resp_t dresp_o [2];
  cbus_req_t  creq_o  [2];
  logic       err_o   [2];

  int checks = 0;
  int errors = 0;

  core_bus_arbiter_if ifa ();
  core_bus_arbiter_if ifb ();

  assign ifa.ireq  = ireq[0];
  assign ifa.dreq  = dreq[0];
  assign ifa.cresp = cresp[0];
  assign ifb.ireq  = ireq[1];
  assign ifb.dreq  = dreq[1];
  assign ifb.cresp = cresp[1];

  assign iresp_o[0] = ifa.iresp;
  assign dresp_o[0] = ifa.dresp;
  assign creq_o[0]  = ifa.creq;
  assign iresp_o[1] = ifb.iresp;
  assign dresp_o[1] = ifb.dresp;
  assign creq_o[1]  = ifb.creq;

  logic err_a, err_b;
  assign err_o[0] = err_a;
  assign err_o[1] = err_b;

  core_bus_arbiter #(.DATA_PRIO(1), .TIMEOUT(TB_TIMEOUT), .CNT_W(16)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa),
    .err   (err_a)
  );

  core_bus_arbiter #(.DATA_PRIO(0), .TIMEOUT(TB_TIMEOUT), .CNT_W(16)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb),
    .err   (err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // owner: 0 none, 1 fetch client, 2 data client
  int        m_owner [2];
  cbus_req_t m_lat   [2];
  int        m_wait  [2];
  bit        m_err   [2];

  task automatic model_cycle(input int k);
    int    g;
    bit    done;
    bit    prio_d;
    string p;
    p      = (k == 0) ? "A" : "B";
    prio_d = (k == 0);
    g      = 0;
    if (!reset && m_owner[k] == 0) begin
      if (dreq[k].valid && ireq[k].valid) g = prio_d ? 2 : 1;
      else if (dreq[k].valid)             g = 2;
      else if (ireq[k].valid)             g = 1;
    end
    done = !reset && (m_owner[k] != 0) && cresp[k].ready && cresp[k].last;

    check({p, " i.addr_ok"}, iresp_o[k].addr_ok, g == 1);
    check({p, " d.addr_ok"}, dresp_o[k].addr_ok, g == 2);
    check({p, " i.data_ok"}, iresp_o[k].data_ok, done && m_owner[k] == 1);
    check({p, " d.data_ok"}, dresp_o[k].data_ok, done && m_owner[k] == 2);
    check({p, " creq.valid"}, creq_o[k].valid, m_owner[k] != 0);
    check({p, " err"}, err_o[k], m_err[k]);
    if (m_owner[k] != 0) begin
      check({p, " creq.addr"},     creq_o[k].addr,     m_lat[k].addr);
      check({p, " creq.is_write"}, creq_o[k].is_write, m_lat[k].is_write);
      check({p, " creq.size"},     creq_o[k].size,     m_lat[k].size);
      check({p, " creq.strobe"},   creq_o[k].strobe,   m_lat[k].strobe);
      check({p, " creq.len"},      creq_o[k].len,      8'd0);
      check({p, " creq.burst"},    creq_o[k].burst,    1'b0);
      if (m_owner[k] == 2) check({p, " creq.data"}, creq_o[k].data, m_lat[k].data);
    end
    if (done && m_owner[k] == 1)
      check({p, " i.data"}, iresp_o[k].data,
            m_lat[k].addr[2] ? cresp[k].data[63:32] : cresp[k].data[31:0]);
    if (done && m_owner[k] == 2)
      check({p, " d.data"}, dresp_o[k].data, cresp[k].data);

    if (reset) begin
      m_owner[k] = 0;
      m_wait[k]  = 0;
      m_err[k]   = 1'b0;
    end else if (m_owner[k] == 0) begin
      m_wait[k] = 0;
      if (g == 1) begin
        m_lat[k]      = '0;
        m_lat[k].addr = ireq[k].addr;
        m_lat[k].size = MSIZE4;
        m_owner[k]    = 1;
      end else if (g == 2) begin
        m_lat[k]          = '0;
        m_lat[k].addr     = dreq[k].addr;
        m_lat[k].size     = dreq[k].size;
        m_lat[k].strobe   = dreq[k].strobe;
        m_lat[k].data     = dreq[k].data;
        m_lat[k].is_write = (dreq[k].strobe != 8'd0);
        m_owner[k]        = 2;
      end
    end else if (done) begin
      m_owner[k] = 0;
      m_wait[k]  = 0;
    end else begin
      m_wait[k]++;
      if (TB_TIMEOUT != 0 && m_wait[k] >= TB_TIMEOUT) m_err[k] = 1'b1;
    end
  endtask

  // Compare on the falling edge; inputs change just after the rising edge.
  initial begin
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = 0;
      m_wait[k]  = 0;
      m_err[k]   = 1'b0;
      m_lat[k]   = '0;
    end
    @(posedge clk);
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) model_cycle(k);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_i(input logic v, input logic [63:0] a);
    for (int k = 0; k < 2; k++) begin
      ireq[k].valid = v;
      ireq[k].addr  = a;
    end
  endtask

  task automatic drive_d(input logic v, input logic [63:0] a, input msize_t s,
                         input logic [7:0] st, input logic [63:0] d);
    for (int k = 0; k < 2; k++) begin
      dreq[k].valid  = v;
      dreq[k].addr   = a;
      dreq[k].size   = s;
      dreq[k].strobe = st;
      dreq[k].data   = d;
    end
  endtask

  task automatic drive_c(input logic r, input logic l, input logic [63:0] d);
    for (int k = 0; k < 2; k++) begin
      cresp[k].ready = r;
      cresp[k].last  = l;
      cresp[k].data  = d;
    end
  endtask

  initial begin
    reset = 1'b1;
    drive_i(1'b0, '0);
    drive_d(1'b0, '0, MSIZE1, '0, '0);
    drive_c(1'b0, 1'b0, '0);
    repeat (2) cyc();

    // ibus read, granted at t, completes at t+3
    cyc(); reset = 1'b0; drive_i(1'b1, 64'h8000_0004); #1;
    check("t1 grant addr_ok", iresp_o[0].addr_ok, 1'b1);
    check("t1 creq idle at grant", creq_o[0].valid, 1'b0);
    cyc(); #1;
    check("t1 creq.valid", creq_o[0].valid, 1'b1);
    check("t1 creq.addr", creq_o[0].addr, 64'h8000_0004);
    check("t1 creq.is_write", creq_o[0].is_write, 1'b0);
    check("t1 creq.size", creq_o[0].size, 3'd2);
    cyc();
    cyc(); drive_c(1'b1, 1'b1, 64'h1111_2222_3333_4444); #1;
    check("t1 data_ok", iresp_o[0].data_ok, 1'b1);
    check("t1 data", iresp_o[0].data, 32'h1111_2222);
    check("t1 dresp quiet", dresp_o[0].data_ok, 1'b0);
    cyc(); drive_i(1'b0, '0); drive_c(1'b0, 1'b0, '0); #1;
    check("t1 creq drops", creq_o[0].valid, 1'b0);

    // dbus write, live address change, ready-without-last ignored
    cyc(); drive_d(1'b1, 64'h8000_1000, MSIZE8, 8'hFF, 64'hDEAD_BEEF); #1;
    check("t2 d.addr_ok", dresp_o[0].addr_ok, 1'b1);
    check("t2 i.addr_ok", iresp_o[0].addr_ok, 1'b0);
    cyc(); dreq[0].addr = 64'h9000_0000; dreq[1].addr = 64'h9000_0000; #1;
    check("t2 is_write", creq_o[0].is_write, 1'b1);
    check("t2 size", creq_o[0].size, 3'd3);
    check("t2 strobe", creq_o[0].strobe, 8'hFF);
    check("t2 data", creq_o[0].data, 64'hDEAD_BEEF);
    check("t2 addr latched", creq_o[0].addr, 64'h8000_1000);
    cyc(); drive_c(1'b1, 1'b0, '0); #1;
    check("t2 no last", dresp_o[0].data_ok, 1'b0);
    check("t2 addr still latched", creq_o[0].addr, 64'h8000_1000);
    cyc(); drive_c(1'b1, 1'b1, 64'h55); #1;
    check("t2 data_ok", dresp_o[0].data_ok, 1'b1);
    check("t2 d.data", dresp_o[0].data, 64'h55);
    check("t2 iresp quiet", iresp_o[0].data_ok, 1'b0);
    cyc(); drive_d(1'b0, '0, MSIZE1, '0, '0); drive_c(1'b0, 1'b0, '0); #1;
    check("t2 one-cycle pulse", dresp_o[0].data_ok, 1'b0);

    // simultaneous requests: A serves dbus first, B serves ibus first
    cyc(); drive_i(1'b1, 64'h8000_0008); drive_d(1'b1, 64'h8000_2000, MSIZE4, 8'h00, '0); #1;
    check("t3 A d grant", dresp_o[0].addr_ok, 1'b1);
    check("t3 A i wait", iresp_o[0].addr_ok, 1'b0);
    check("t3 B i grant", iresp_o[1].addr_ok, 1'b1);
    check("t3 B d wait", dresp_o[1].addr_ok, 1'b0);
    cyc(); #1;
    check("t3 A creq.addr", creq_o[0].addr, 64'h8000_2000);
    check("t3 B creq.addr", creq_o[1].addr, 64'h8000_0008);
    cyc(); drive_c(1'b1, 1'b1, 64'hAAAA_BBBB_CCCC_DDDD); #1;
    check("t3 A d.data_ok", dresp_o[0].data_ok, 1'b1);
    check("t3 B i.data", iresp_o[1].data, 32'hCCCC_DDDD);
    cyc(); drive_c(1'b0, 1'b0, '0); dreq[0].valid = 1'b0; ireq[1].valid = 1'b0; #1;
    check("t3 A gap", creq_o[0].valid, 1'b0);
    check("t3 A i grant", iresp_o[0].addr_ok, 1'b1);
    check("t3 B d grant", dresp_o[1].addr_ok, 1'b1);
    cyc(); #1;
    check("t3 A i creq.valid", creq_o[0].valid, 1'b1);
    check("t3 A i creq.addr", creq_o[0].addr, 64'h8000_0008);
    cyc(); drive_c(1'b1, 1'b1, 64'h0123_4567_89AB_CDEF); #1;
    check("t3 A i.data", iresp_o[0].data, 32'h89AB_CDEF);
    check("t3 B d.data_ok", dresp_o[1].data_ok, 1'b1);
    cyc(); drive_i(1'b0, '0); drive_d(1'b0, '0, MSIZE1, '0, '0); drive_c(1'b0, 1'b0, '0);

    // watchdog: 8 busy cycles without completion
    cyc(); drive_d(1'b1, 64'h8000_3000, MSIZE8, 8'h0F, 64'h1234); #1;
    check("t5 grant", dresp_o[0].addr_ok, 1'b1);
    repeat (8) cyc();
    #1;
    check("t5 err before limit", err_o[0], 1'b0);
    cyc(); #1;
    check("t5 A err set", err_o[0], 1'b1);
    check("t5 B err set", err_o[1], 1'b1);
    cyc(); drive_c(1'b1, 1'b1, 64'h77); #1;
    check("t5 late completion", dresp_o[0].data_ok, 1'b1);
    cyc(); drive_d(1'b0, '0, MSIZE1, '0, '0); drive_c(1'b0, 1'b0, '0); #1;
    check("t5 err sticky", err_o[0], 1'b1);

    // reset two cycles into a dbus transaction, pending ibus afterwards
    cyc(); drive_d(1'b1, 64'h8000_4000, MSIZE8, 8'hFF, 64'hCAFE); #1;
    check("t4 d grant", dresp_o[0].addr_ok, 1'b1);
    cyc();
    cyc(); reset = 1'b1; drive_i(1'b1, 64'h8000_0010); #1;
    check("t4 no grant in reset", iresp_o[0].addr_ok, 1'b0);
    cyc(); reset = 1'b0; drive_d(1'b0, '0, MSIZE1, '0, '0); drive_c(1'b1, 1'b1, 64'h99); #1;
    check("t4 creq abandoned", creq_o[0].valid, 1'b0);
    check("t4 no data_ok", dresp_o[0].data_ok, 1'b0);
    check("t4 err cleared", err_o[0], 1'b0);
    check("t4 i grant", iresp_o[0].addr_ok, 1'b1);
    cyc(); drive_c(1'b0, 1'b0, '0); #1;
    check("t4 i creq.addr", creq_o[0].addr, 64'h8000_0010);
    cyc(); drive_c(1'b1, 1'b1, 64'hFEDC_BA98_7654_3210); #1;
    check("t4 i.data_ok", iresp_o[0].data_ok, 1'b1);
    check("t4 i.data", iresp_o[0].data, 32'h7654_3210);
    cyc(); drive_i(1'b0, '0); drive_c(1'b0, 1'b0, '0);
    repeat (3) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
